ccff_chain_loader: RTL

//  Drives a configuration-chain (ccff) shift path: accepts bitstream words from the config host

---
 rtl/ccff_loader_pkg.sv | 10 +
 rtl/ccff_readback_packer.sv | 62 ++++++
 rtl/ccff_chain_loader.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types for the ccff chain loader: the pass-level FSM state encoding.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ccff_ld_state_t;

endpackage

// File: rtl/ccff_readback_packer.sv
// Captures bits leaving the ccff chain tail and packs them LSB-first into readback
// words, holding each word on a valid/ready register until the consumer takes it.
module ccff_readback_packer #(
    parameter int WORD_W = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              i_clear,
    input  logic              i_capture,
    input  logic              i_last,
    input  logic              i_tail,
    input  logic              i_rb_ready,
    output logic              o_rb_valid,
    output logic [WORD_W-1:0] o_rb_data
);
    localparam int RC_W = $clog2(WORD_W + 1);

    logic [RC_W-1:0]   r_cnt;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] r_data;
    logic              r_valid;
    logic [WORD_W-1:0] w_shift_next;
    logic              w_word_done;

    // Positions at and above r_cnt are always zero, so OR-ing in the new bit is enough
    // and leaves the upper bits of a partial final word at zero.
    assign w_shift_next = r_shift | (WORD_W'(i_tail) << r_cnt);
    assign w_word_done  = i_capture && (i_last || (r_cnt == RC_W'(WORD_W - 1)));

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_clear) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (i_capture) begin
                if (w_word_done) begin
                    r_cnt   <= '0;
                    r_shift <= '0;
                    r_data  <= w_shift_next;
                end else begin
                    r_cnt   <= r_cnt + RC_W'(1);
                    r_shift <= w_shift_next;
                end
            end

            if (w_word_done) begin
                r_valid <= 1'b1;
            end else if (r_valid && i_rb_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_rb_valid = r_valid;
    assign o_rb_data  = r_data;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises host words onto a ccff chain head with a gated shift enable, and
// returns the bits leaving the chain tail as packed readback words.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 3,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              ccff_head,
    output logic              shift_en,
    input  logic              ccff_tail,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic [WORD_W-1:0] rb_data
);
    import ccff_loader_pkg::*;

    localparam int BL_W = $clog2(WORD_W + 1);
    localparam int MW   = (CNT_W > BL_W) ? CNT_W : BL_W;

    ccff_ld_state_t    r_state;
    ccff_ld_state_t    w_state_next;
    logic [CNT_W-1:0]  r_total_left;
    logic [CNT_W-1:0]  r_load_left;
    logic [BL_W-1:0]   r_bits_left;
    logic [WORD_W-1:0] r_word;

    logic              w_stall;
    logic              w_load;
    logic              w_last_bit;
    logic              w_start_pass;
    logic [BL_W-1:0]   w_load_bits;

    assign w_stall      = rb_valid && !rb_ready;
    assign shift_en     = (r_state == SHIFT) && (r_bits_left != '0) && !w_stall;
    assign ccff_head    = r_word[0];
    // Prefetch: a word may land on the same edge that shifts out the last bit of the
    // previous one, so back-to-back words keep shift_en high without a bubble.
    assign in_ready     = (r_state == SHIFT) && (r_load_left != '0) &&
                          ((r_bits_left == '0) || ((r_bits_left == BL_W'(1)) && shift_en));
    assign w_load       = in_valid && in_ready;
    assign w_last_bit   = shift_en && (r_total_left == CNT_W'(1));
    assign w_start_pass = (r_state == IDLE) && start;
    assign w_load_bits  = (MW'(r_load_left) > MW'(WORD_W)) ? BL_W'(WORD_W)
                                                           : BL_W'(r_load_left);

    // NOTE: every output of this block gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last_bit) w_state_next = DONE;
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples the
    // pre-edge values, matching how the hardware behaves.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            r_state      <= IDLE;
            r_total_left <= '0;
            r_load_left  <= '0;
            r_bits_left  <= '0;
            r_word       <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start_pass) begin
                r_total_left <= CNT_W'(CHAIN_LEN);
                r_load_left  <= CNT_W'(CHAIN_LEN);
                r_bits_left  <= '0;
                r_word       <= '0;
            end else begin
                if (shift_en) r_total_left <= r_total_left - CNT_W'(1);
                if (w_load) begin
                    r_word      <= in_data;
                    r_bits_left <= w_load_bits;
                    r_load_left <= r_load_left - CNT_W'(w_load_bits);
                end else if (shift_en) begin
                    r_word      <= r_word >> 1;
                    r_bits_left <= r_bits_left - BL_W'(1);
                end
            end
        end
    end

    ccff_readback_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .i_clear    (w_start_pass),
        .i_capture  (shift_en),
        .i_last     (w_last_bit),
        .i_tail     (ccff_tail),
        .i_rb_ready (rb_ready),
        .o_rb_valid (rb_valid),
        .o_rb_data  (rb_data)
    );

endmodule
